// File: rtl/avalon_st_packet_arbiter_if.sv
// avalon_st_if: Avalon-ST stream bundle. Forward path carries valid/data/sop/eop,
// the return path carries ready. The arbiter drives it through the master modport.
interface avalon_st_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
    logic                  ready;

    modport master (
        output valid,
        output data,
        output sop,
        output eop,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  sop,
        input  eop,
        output ready
    );
endinterface

// File: rtl/avalon_st_packet_arbiter.sv
// avalon_st_packet_arbiter: packet-atomic round-robin arbiter sharing one Avalon-ST
// consumer between NUM_INPUTS sources. A grant is taken on an sop beat and held
// until the matching eop beat is accepted; the output is one registered stage.
// Optional orphan-beat dropping in IDLE is enabled by defining AVST_ARB_DROP_ORPHAN_EN.
module avalon_st_packet_arbiter #(
    parameter  int NUM_INPUTS = 4,
    parameter  int DATA_WIDTH = 16,
    localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_sop,
    input  logic [NUM_INPUTS-1:0]            in_eop,
    output logic [NUM_INPUTS-1:0]            in_ready,
    avalon_st_if.master                      data_out,
    output logic [IDX_W-1:0]                 grant_id,
    output logic                             busy,
    output logic [15:0]                      drop_cnt
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      last_q,  last_d;
    logic                  valid_q, valid_d;
    logic                  sop_q,   sop_d;
    logic                  eop_q,   eop_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;

    logic [NUM_INPUTS-1:0] eligible;
    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      cand;

    logic                  sel_valid;
    logic                  sel_sop;
    logic                  sel_eop;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  out_free;
    logic                  accept;
    logic [NUM_INPUTS-1:0] grant_ready;

    assign eligible = in_valid & in_sop;
    assign out_free = !valid_q || data_out.ready;
    assign accept   = (state_q == ST_LOCKED) && sel_valid && out_free;

    // Round-robin search starting one past the last source that completed a packet.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_INPUTS);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the granted source's beat for the output register.
    always_comb begin
        sel_valid = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_valid = in_valid[i];
                sel_sop   = in_sop[i];
                sel_eop   = in_eop[i];
                sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the granted source sees ready, and only while the output stage can take a beat.
    always_comb begin
        grant_ready = '0;
        if (state_q == ST_LOCKED) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (grant_q == IDX_W'(i)) begin
                    grant_ready[i] = out_free;
                end
            end
        end
    end

`ifdef AVST_ARB_DROP_ORPHAN_EN
    logic [NUM_INPUTS-1:0] orphan;
    logic [4:0]            orphan_n;
    logic [15:0]           drop_q, drop_d;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {12'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Mid-packet beats seen with no grant held are swallowed and counted.
    always_comb begin
        orphan   = (state_q == ST_IDLE) ? (in_valid & ~in_sop) : '0;
        orphan_n = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            orphan_n = orphan_n + 5'(orphan[i]);
        end
        drop_d = sat_add16(drop_q, orphan_n);
    end

    // Saturating orphan counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign in_ready = grant_ready | orphan;
    assign drop_cnt = drop_q;
`else
    assign in_ready = grant_ready;
    assign drop_cnt = 16'h0000;
`endif

    // FSM and output-register next state: grant on sop in IDLE, release on accepted eop.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_LOCKED;
                    grant_d = win_idx;
                end
            end
            ST_LOCKED: begin
                if (accept && sel_eop) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            valid_d = 1'b1;
            sop_d   = sel_sop;
            eop_d   = sel_eop;
            data_d  = sel_data;
        end else if (data_out.ready) begin
            valid_d = 1'b0;
        end
    end

    // State, grant bookkeeping and output stage; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_INPUTS - 1);
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
        end
    end

    assign data_out.valid = valid_q;
    assign data_out.data  = data_q;
    assign data_out.sop   = sop_q;
    assign data_out.eop   = eop_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// tb_avalon_st_packet_arbiter: directed scenarios plus randomized packet traffic
// checked against a packet-level round-robin reference model.
module tb_avalon_st_packet_arbiter;
    localparam int NI = 4;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NI-1:0]   in_valid = '0;
    logic [NI-1:0]   in_sop = '0;
    logic [NI-1:0]   in_eop = '0;
    logic [NI*DW-1:0] in_data = '0;
    logic [NI-1:0]   in_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic [15:0]     drop_cnt;

    avalon_st_if #(.DATA_WIDTH(DW)) out_if ();

    avalon_st_packet_arbiter #(.NUM_INPUTS(NI), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .in_ready (in_ready),
        .data_out (out_if),
        .grant_id (grant_id),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Per-source beat stores and the packet list each source was given.
    beat_t smem [NI][64];
    int    slen [NI];
    int    shd  [NI];
    int    pk_first [NI][16];
    int    pk_len   [NI][16];
    int    npk  [NI];

    beat_t out_log [$];
    int    out_cyc [$];
    logic  busy_log [$];
    beat_t exp_q [$];
    logic  rdy_pat [$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          orph_n = 0;
    int          orph_rdy = 0;
    bit          gap_en = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          hold_pending = 1'b0;
    logic [31:0] hold_val = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic add_pkt(input int s, input int len, input logic [15:0] first);
        pk_first[s][npk[s]] = int'(first);
        pk_len[s][npk[s]]   = len;
        npk[s]++;
        for (int i = 0; i < len; i++) begin
            smem[s][slen[s]] = '{data: first + 16'(i), sop: (i == 0), eop: (i == len - 1)};
            slen[s]++;
        end
    endtask

    // Packet-level round-robin: after reset source 0 is first; after each packet the
    // search resumes one past the source that was just served.
    task automatic build_rr();
        int nxt [NI];
        int ptr;
        int s;
        int c;
        int total;
        bit found;
        exp_q.delete();
        ptr = 0;
        total = 0;
        for (int i = 0; i < NI; i++) begin
            nxt[i] = 0;
            total += npk[i];
        end
        for (int p = 0; p < total; p++) begin
            found = 1'b0;
            s = 0;
            for (int k = 0; k < NI; k++) begin
                c = (ptr + k) % NI;
                if (!found && nxt[c] < npk[c]) begin
                    found = 1'b1;
                    s = c;
                end
            end
            for (int i = 0; i < pk_len[s][nxt[s]]; i++) begin
                exp_q.push_back('{data: 16'(pk_first[s][nxt[s]]) + 16'(i),
                                  sop: (i == 0), eop: (i == pk_len[s][nxt[s]] - 1)});
            end
            nxt[s]++;
            ptr = (s + 1) % NI;
        end
    endtask

    // One clock: drive at negedge, sample just after, advance queues after posedge.
    task automatic step();
        logic [NI-1:0] acc;
        logic [NI-1:0] from_q;
        beat_t         b;
        bit            orph_now;
        @(negedge clk);
        from_q = '0;
        orph_now = 1'b0;
        for (int s = 0; s < NI; s++) begin
            in_valid[s] = 1'b0;
            in_sop[s] = 1'b0;
            in_eop[s] = 1'b0;
            in_data[s*DW +: DW] = '0;
            if (shd[s] < slen[s]) begin
                b = smem[s][shd[s]];
                if (b.sop || !gap_en || ($urandom_range(0, 3) != 0)) begin
                    in_valid[s] = 1'b1;
                    in_sop[s] = b.sop;
                    in_eop[s] = b.eop;
                    in_data[s*DW +: DW] = b.data;
                    from_q[s] = 1'b1;
                end
            end
        end
        if (orph_n > 0) begin
            in_valid[1] = 1'b1;
            in_sop[1] = 1'b0;
            in_eop[1] = 1'b0;
            in_data[DW +: DW] = 16'hDEAD;
            from_q[1] = 1'b0;
            orph_now = 1'b1;
            orph_n--;
        end
        if (rdy_pat.size() > 0) out_if.ready = rdy_pat.pop_front();
        else if (rand_rdy)      out_if.ready = ($urandom_range(0, 2) != 0);
        else                    out_if.ready = 1'b1;
        #1;
        acc = in_valid & in_ready & from_q;
        if (orph_now && in_ready[1]) orph_rdy++;
        busy_log.push_back(busy);
        if (hold_pending)
            check_eq("hold", 32'({out_if.valid, out_if.data, out_if.sop, out_if.eop}), hold_val);
        if (busy && out_if.valid && !out_if.ready)
            check_eq("bp_ready", 32'(in_ready), 32'(0));
        if (out_if.valid && out_if.ready) begin
            out_log.push_back('{data: out_if.data, sop: out_if.sop, eop: out_if.eop});
            out_cyc.push_back(cyc);
        end
        hold_pending = out_if.valid && !out_if.ready;
        hold_val = 32'({out_if.valid, out_if.data, out_if.sop, out_if.eop});
        @(posedge clk);
        cyc++;
        #1;
        for (int s = 0; s < NI; s++) begin
            if (acc[s]) shd[s]++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_valid"}, 32'(out_if.valid), 32'(0));
        check_eq({tag, "_sop"},   32'(out_if.sop),   32'(0));
        check_eq({tag, "_eop"},   32'(out_if.eop),   32'(0));
        check_eq({tag, "_data"},  32'(out_if.data),  32'(0));
        check_eq({tag, "_grant"}, 32'(grant_id),     32'(0));
        check_eq({tag, "_busy"},  32'(busy),         32'(0));
        check_eq({tag, "_ready"}, 32'(in_ready),     32'(0));
        check_eq({tag, "_drop"},  32'(drop_cnt),     32'(0));
    endtask

    task automatic do_reset(input bit check_state);
        for (int s = 0; s < NI; s++) begin
            slen[s] = 0;
            shd[s] = 0;
            npk[s] = 0;
        end
        out_log.delete();
        out_cyc.delete();
        rdy_pat.delete();
        gap_en = 1'b0;
        rand_rdy = 1'b0;
        orph_n = 0;
        orph_rdy = 0;
        rst = 1'b1;
        step();
        step();
        if (check_state) check_reset_state("rst");
        rst = 1'b0;
        hold_pending = 1'b0;
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [15:0] d,
                              input logic sop, input logic eop);
        beat_t want;
        want = '{data: d, sop: sop, eop: eop};
        check_eq(tag, 32'(out_log[idx]), 32'(want));
    endtask

    initial begin
        int c0;
        int ones;
        int rises;
        out_if.ready = 1'b1;

        // Reset state and single-source 10-beat packet.
        do_reset(1'b1);
        add_pkt(0, 10, 16'h0000);
        c0 = cyc;
        for (int i = 0; i < 14; i++) step();
        check_eq("s1_busy_before", 32'(busy_log[c0]), 32'(0));
        check_eq("s1_busy_after",  32'(busy_log[c0 + 1]), 32'(1));
        check_eq("s1_grant", 32'(grant_id), 32'(0));
        check_eq("s1_count", 32'(out_log.size()), 32'(10));
        check_eq("s1_latency", 32'(out_cyc[0] - c0), 32'(2));
        for (int i = 0; i < 10; i++)
            check_beat("s1_beat", i, 16'(i), (i == 0), (i == 9));

        // Round-robin across sources 0,1,2, then 0 beats 2 because 2 was last served.
        do_reset(1'b0);
        add_pkt(0, 3, 16'h0000);
        add_pkt(1, 3, 16'h1000);
        add_pkt(2, 3, 16'h2000);
        c0 = cyc;
        for (int i = 0; i < 16; i++) step();
        check_eq("rr_count", 32'(out_log.size()), 32'(9));
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 3; b++) begin
                check_beat("rr_beat", 3*p + b, 16'(p * 16'h1000 + b), (b == 0), (b == 2));
                check_eq("rr_cycle", 32'(out_cyc[3*p + b]), 32'(c0 + 2 + 4*p + b));
            end
        end
        out_log.delete();
        out_cyc.delete();
        add_pkt(0, 2, 16'h0A00);
        add_pkt(2, 2, 16'h2A00);
        for (int i = 0; i < 10; i++) step();
        check_eq("rr2_count", 32'(out_log.size()), 32'(4));
        check_beat("rr2_b0", 0, 16'h0A00, 1'b1, 1'b0);
        check_beat("rr2_b1", 1, 16'h0A01, 1'b0, 1'b1);
        check_beat("rr2_b2", 2, 16'h2A00, 1'b1, 1'b0);
        check_beat("rr2_b3", 3, 16'h2A01, 1'b0, 1'b1);

        // Backpressure with ready pattern 1,0,0,1,1,0,1 from the first output beat.
        do_reset(1'b0);
        add_pkt(0, 5, 16'h0500);
        step();
        step();
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) step();
        check_eq("bp_count", 32'(out_log.size()), 32'(5));
        for (int i = 0; i < 5; i++)
            check_beat("bp_beat", i, 16'h0500 + 16'(i), (i == 0), (i == 4));

        // Single-beat packets from sources 1 and 3.
        do_reset(1'b0);
        add_pkt(1, 1, 16'h00AA);
        add_pkt(3, 1, 16'h00BB);
        c0 = cyc;
        for (int i = 0; i < 8; i++) step();
        check_eq("sb_count", 32'(out_log.size()), 32'(2));
        check_beat("sb_b0", 0, 16'h00AA, 1'b1, 1'b1);
        check_beat("sb_b1", 1, 16'h00BB, 1'b1, 1'b1);
        ones = 0;
        rises = 0;
        for (int k = c0; k < cyc; k++) begin
            if (busy_log[k]) ones++;
            if (busy_log[k] && (k == c0 || !busy_log[k - 1])) rises++;
        end
        check_eq("sb_busy_cycles", 32'(ones), 32'(2));
        check_eq("sb_busy_pulses", 32'(rises), 32'(2));

        // Reset while source 2 is mid-packet, then source 0 sends a 2-beat packet.
        do_reset(1'b0);
        add_pkt(2, 8, 16'h2000);
        for (int i = 0; i < 20 && shd[2] < 3; i++) step();
        check_eq("mid_reach", 32'(shd[2]), 32'(3));
        rst = 1'b1;
        step();
        check_reset_state("mid");
        rst = 1'b0;
        slen[2] = shd[2];
        hold_pending = 1'b0;
        out_log.delete();
        out_cyc.delete();
        add_pkt(0, 2, 16'h0100);
        for (int i = 0; i < 8; i++) step();
        check_eq("mid_grant", 32'(grant_id), 32'(0));
        check_eq("mid_count", 32'(out_log.size()), 32'(2));
        check_beat("mid_b0", 0, 16'h0100, 1'b1, 1'b0);
        check_beat("mid_b1", 1, 16'h0101, 1'b0, 1'b1);

        // Orphan beats from source 1 while idle, then a packet from source 0.
        do_reset(1'b0);
        orph_n = 3;
        for (int i = 0; i < 3; i++) step();
        add_pkt(0, 3, 16'h0300);
        for (int i = 0; i < 8; i++) step();
`ifdef AVST_ARB_DROP_ORPHAN_EN
        check_eq("orph_drop_cnt", 32'(drop_cnt), 32'(3));
        check_eq("orph_ready", 32'(orph_rdy), 32'(3));
`else
        check_eq("orph_drop_cnt", 32'(drop_cnt), 32'(0));
        check_eq("orph_ready", 32'(orph_rdy), 32'(0));
`endif
        check_eq("orph_count", 32'(out_log.size()), 32'(3));
        for (int i = 0; i < 3; i++)
            check_beat("orph_beat", i, 16'h0300 + 16'(i), (i == 0), (i == 2));

        // Randomized traffic: all sources offer their packets back to back.
        for (int r = 0; r < 4; r++) begin
            do_reset(1'b0);
            for (int s = 0; s < NI; s++) begin
                int n;
                n = $urandom_range(0, 3);
                if (s == 0 && n == 0) n = 1;
                for (int k = 0; k < n; k++)
                    add_pkt(s, $urandom_range(1, 6),
                            {4'(s), 4'(k), 8'($urandom_range(0, 249))});
            end
            build_rr();
            gap_en = 1'b1;
            rand_rdy = 1'b1;
            for (int i = 0; i < 3000 && out_log.size() < exp_q.size(); i++) step();
            check_eq("rand_count", 32'(out_log.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++)
                check_eq("rand_beat", 32'(out_log[i]), 32'(exp_q[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/avalon_st_packet_arbiter.md
# avalon_st_packet_arbiter

Packet-atomic round-robin arbiter that shares one Avalon-ST consumer, typically a `header_remover` instance, between `NUM_INPUTS` upstream packet sources. A grant is taken on a start-of-packet (`sop`) beat and held until the matching end-of-packet (`eop`) beat is accepted, so packets from different sources never interleave. The output passes through one registered pipeline stage so that it meets timing into the downstream block.

## Interface
- `NUM_INPUTS`, default 4: number of requesters; legal range 2..16.
- `DATA_WIDTH`, default 16: beat width in bits; must match the downstream `data_in` width.
- `IDX_W`, derived as `$clog2(NUM_INPUTS)`: grant index width. Not to be overridden.

Ports:
- `clk`  in  1  Single clock; all logic is on the rising edge.
- `rst`  in  1  Reset, synchronous, active-high.
- `in_valid`  in  NUM_INPUTS  Per-source valid.
- `in_data`  in  NUM_INPUTS*DATA_WIDTH  Per-source data; source i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_sop`  in  NUM_INPUTS  Per-source start-of-packet.
- `in_eop`  in  NUM_INPUTS  Per-source end-of-packet.
- `in_ready`  out  NUM_INPUTS  Per-source ready.
- `data_out`  modport master  avalon_st_if #(DATA_WIDTH)  Arbitrated stream (valid/data/sop/eop out, ready in).
- `grant_id`  out  IDX_W  Index of the currently or most recently granted source.
- `busy`  out  1  High while the FSM is in LOCKED.
- `drop_cnt`  out  16  Count of discarded orphan beats; saturates at 0xFFFF.

## Operation
- FSM states:
  - IDLE: no grant is held; the arbiter evaluates requests.
  - LOCKED: a packet is in flight from source `grant_id`.
- Eligibility in IDLE: source i is eligible when `in_valid[i] && in_sop[i]`.
- Round-robin selection: the search starts at `last+1` and wraps modulo NUM_INPUTS. The first eligible source is latched into `grant_id`, and the FSM moves IDLE→LOCKED on the next edge.
- `last` is updated to `grant_id` when the `eop` beat of the granted packet is accepted.
- Ready in LOCKED: `in_ready[grant_id] = !data_out.valid || data_out.ready`. All other `in_ready` bits are 0.
- Ready in IDLE: all `in_ready` are 0, except for orphan dropping (see Configuration).
- Accept: a beat is accepted when `in_valid[g] && in_ready[g]`. The accepted data, sop and eop are registered into the output stage on the same edge, and `data_out.valid` is set.
- The output register clears `valid` when `data_out.ready` is high and no new beat is accepted that cycle.
- Packet end: when an accepted beat has `eop=1`, the FSM moves LOCKED→IDLE on that edge.
- Single-beat packets (`sop=eop=1`) are legal: one LOCKED cycle, then back to IDLE.
- A `sop` seen mid-packet from the granted source is forwarded unchanged and does not restart arbitration.
- Requests from non-granted sources are ignored in LOCKED. They remain pending; sources must hold `valid`.

## Timing
- Reset values: `in_ready=0`, `data_out.valid/sop/eop=0`, `data_out.data=0`, `grant_id=0`, `busy=0`, `drop_cnt=0`.
  - On reset, `last` is set to NUM_INPUTS-1 so that source 0 has first priority.
- Reset during LOCKED:
  - The packet is abandoned.
  - The output register is cleared and the FSM returns to IDLE.
  - No `eop` is synthesised.
- Grant latency: an eligible request seen in IDLE at edge N gives `busy=1` and `in_ready` high after edge N. The first beat is accepted at edge N+1.
- Data latency: exactly 1 cycle from accept to `data_out.valid`.
- Throughput: 1 beat/cycle inside a packet while `data_out.ready` is held high.
- Packet gap: at least one IDLE cycle after each `eop`, so the minimum spacing between packets from any sources is 1 bubble cycle.
- Backpressure: while `data_out.valid && !data_out.ready`, the output register holds its value and `in_ready[grant_id]=0`. No beat is lost or duplicated.
- All outputs are driven from registers, except `in_ready`, which is combinational from the state, `grant_id`, `data_out.valid` and `data_out.ready`.

## Configuration
- Macro: `AVST_ARB_DROP_ORPHAN_EN`.
- When defined:
  - In IDLE, any source with `in_valid && !in_sop` is an orphan. It receives `in_ready=1` that cycle and the beat is discarded.
  - `drop_cnt` increments by the number of orphans dropped that cycle, saturating at 0xFFFF.
  - Orphans are never forwarded.
  - Eligible sources are arbitrated in the same cycle, unaffected by orphan dropping.
- When not defined: orphans receive `in_ready=0` and are never granted, so such a source stalls until reset. `drop_cnt` is tied to 0.

## Test plan
- Single source: source 0 sends a 10-beat packet with data 0..9, `out.ready=1`.
  - Required: `grant_id=0`; `busy` rises 1 cycle after the first `sop`; output is data 0..9 with `sop` on 0 and `eop` on 9; output starts 2 cycles after `in_valid`.
- Round-robin: sources 0, 1 and 2 all present a 3-beat packet at the same time, after reset.
  - Required: output order is 0, 1, 2, each packet contiguous, with 1 bubble cycle between packets.
  - Then source 0 requests again, and source 2 is re-offered with a new packet: source 0 wins, since `last=2`.
- Backpressure: a 5-beat packet with `out.ready` toggling 1,0,0,1,1,0,1.
  - Required: the output shows each beat exactly once, in order; `data_out` is stable while `ready=0`.
- Single-beat packets: sources 1 and 3 each send a packet with `sop=eop=1` (data 0xAA and 0xBB).
  - Required: two output beats, 0xAA then 0xBB, each with `sop=eop=1`; `busy` pulses for 1 cycle per packet.
- Reset mid-packet: `rst` is asserted at beat 4 of 8 from source 2, then source 0 sends a 2-beat packet.
  - Required: all outputs equal their reset values on the next edge; source 0 is then granted and its packet is forwarded intact.
- Orphan handling: source 1 drives `valid` with `sop=0` for 3 cycles while IDLE, and source 0 sends a packet.
  - With the macro defined: `drop_cnt=3`, and source 0's packet is forwarded.
  - Without the macro: `in_ready[1]` stays 0 and `drop_cnt=0`.
